// File: rtl/greedy_snake_pkg.sv
// Shared definitions for the GreedySnake direction/tick controller.
//   forward_t        : 2-bit committed-direction encoding driven on `forward`
//   KEY_* offsets    : bit position of each direction key inside a player's
//                      4-bit slice of key_dir
//   tick_period()    : movement period for a given speed level (elaboration
//                      time only; used to build the period lookup table)
package greedy_snake_pkg;

  typedef enum logic [1:0] {
    FORWARD_X_UP   = 2'b00,
    FORWARD_X_DOWN = 2'b01,
    FORWARD_Y_UP   = 2'b10,
    FORWARD_Y_DOWN = 2'b11
  } forward_t;

  localparam int KEY_X_UP        = 0;
  localparam int KEY_X_DOWN      = 1;
  localparam int KEY_Y_UP        = 2;
  localparam int KEY_Y_DOWN      = 3;
  localparam int KEYS_PER_PLAYER = 4;

  // The upper encoding bit selects the axis: 0 = X, 1 = Y.
  function automatic logic is_y_axis(input logic [1:0] dir);
    return dir[1];
  endfunction

  // Period = max(min_cnt, base - level*step).
  function automatic int tick_period(input int level, input int base,
                                     input int step, input int min_cnt);
    int p;
    p = base - level * step;
    if (p < min_cnt) p = min_cnt;
    return p;
  endfunction

endpackage

// File: rtl/greedy_snake_key_debounce.sv
// Key conditioner: 2-FF synchroniser, level debouncer and rising-edge pulse.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   key   : raw active-high push-button
//   press : one-cycle pulse on the debounced rising edge
// The debounced level follows the synchronised key only after DEBOUNCE_CNT
// consecutive samples that differ from the current level. From a raw edge to
// the press pulse takes 2 + DEBOUNCE_CNT + 1 cycles.
module greedy_snake_key_debounce #(
  parameter int DEBOUNCE_CNT = 270_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others (sync1 -> sync2 must be a real 2-stage
  // pipeline, not a single wire).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      // Any sample equal to the current level restarts the stability count.
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/greedy_snake_dir_ctrl.sv
// GreedySnake multi-player direction and movement-tick controller.
//   clk            : system clock
//   rst            : asynchronous active-low reset
//   key_dir        : raw direction keys, player p at [4p+3:4p]
//                    (x_up, x_down, y_up, y_down from bit 0 upward)
//   key_pause      : raw pause toggle key
//   key_speed_up   : raw speed increment key
//   key_speed_down : raw speed decrement key
//   en             : one-cycle movement tick
//   forward        : committed direction, player p at [2p+1:2p]
//   paused         : high while the game is paused
//   speed_level    : current speed level, 0..SPEED_LEVELS-1
// Optional build macro GREEDY_SNAKE_AUTO_SPEED_EN: when defined, speed_level
// also steps up (saturating) every AUTO_STEP_TICKS movement ticks.
module greedy_snake_dir_ctrl
  import greedy_snake_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int TICK_BASE_CNT   = 27_000_000,
  parameter int SPEED_STEP_CNT  = 2_700_000,
  parameter int MIN_TICK_CNT    = 5_400_000,
  parameter int SPEED_LEVELS    = 8,
  parameter int DEBOUNCE_CNT    = 270_000,
  parameter int AUTO_STEP_TICKS = 32,
  localparam int SW = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*NUM_PLAYERS-1:0] key_dir,
  input  logic                     key_pause,
  input  logic                     key_speed_up,
  input  logic                     key_speed_down,
  output logic                     en,
  output logic [2*NUM_PLAYERS-1:0] forward,
  output logic                     paused,
  output logic [SW-1:0]            speed_level
);

  localparam int NK        = KEYS_PER_PLAYER * NUM_PLAYERS + 3;
  localparam int PAUSE_IDX = KEYS_PER_PLAYER * NUM_PLAYERS;
  localparam int UP_IDX    = PAUSE_IDX + 1;
  localparam int DOWN_IDX  = PAUSE_IDX + 2;
  localparam int CW        = $clog2(TICK_BASE_CNT + 1);
  localparam logic [SW-1:0] MAX_LEVEL = SW'(SPEED_LEVELS - 1);

  // ---------------------------------------------------------------- keys
  logic [NK-1:0] raw;
  logic [NK-1:0] ev;

  assign raw = {key_speed_down, key_speed_up, key_pause, key_dir};

  for (genvar k = 0; k < NK; k++) begin : g_key
    greedy_snake_key_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .key  (raw[k]),
      .press(ev[k])
    );
  end

  logic [NUM_PLAYERS-1:0][KEYS_PER_PLAYER-1:0] dir_ev;
  logic pause_ev;
  logic up_ev;
  logic down_ev;

  assign dir_ev   = ev[PAUSE_IDX-1:0];
  assign pause_ev = ev[PAUSE_IDX];
  assign up_ev    = ev[UP_IDX];
  assign down_ev  = ev[DOWN_IDX];

  // --------------------------------------------------------- tick period
  // The period per level is a constant table, so a level change is just a
  // different lookup for the in-flight count.
  logic [CW-1:0] period_lut [SPEED_LEVELS];

  for (genvar l = 0; l < SPEED_LEVELS; l++) begin : g_period
    assign period_lut[l] =
      CW'(tick_period(l, TICK_BASE_CNT, SPEED_STEP_CNT, MIN_TICK_CNT));
  end

  logic [CW-1:0] period;
  logic [CW-1:0] cnt;
  logic          wrap;

  assign period = period_lut[speed_level];
  // `>=` rather than `==`: a speed-up can shrink the period below the count.
  assign wrap   = !paused && (cnt >= period - CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      en  <= 1'b0;
    end else if (paused) begin
      en <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      en  <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      en  <= 1'b0;
    end
  end

  // A pause event on the wrap cycle still lets that tick complete, because
  // `wrap` looks at the pre-edge paused value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          paused <= 1'b0;
    else if (pause_ev) paused <= ~paused;
  end

  // ---------------------------------------------------------- speed level
  logic auto_step;

`ifdef GREEDY_SNAKE_AUTO_SPEED_EN
  localparam int AW = (AUTO_STEP_TICKS > 1) ? $clog2(AUTO_STEP_TICKS) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_STEP_TICKS - 1);

  logic [AW-1:0] auto_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_cnt <= '0;
    end else if (wrap) begin
      auto_cnt <= (auto_cnt == AUTO_LAST) ? '0 : auto_cnt + 1'b1;
    end
  end

  assign auto_step = wrap && (auto_cnt == AUTO_LAST);
`else
  // Never true: automatic stepping is compiled out in this build.
  assign auto_step = (AUTO_STEP_TICKS < 0);
`endif

  logic [SW-1:0] level_nxt;

  // NOTE: every variable written here gets its default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    level_nxt = speed_level;
    // Simultaneous up and down events cancel.
    if (up_ev && !down_ev && speed_level != MAX_LEVEL) begin
      level_nxt = speed_level + 1'b1;
    end else if (down_ev && !up_ev && speed_level != '0) begin
      level_nxt = speed_level - 1'b1;
    end
    if (auto_step && level_nxt != MAX_LEVEL) begin
      level_nxt = level_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) speed_level <= '0;
    else      speed_level <= level_nxt;
  end

  // ----------------------------------------------------------- directions
  logic [NUM_PLAYERS-1:0][1:0] committed;
  logic [NUM_PLAYERS-1:0][1:0] pending;
  logic [NUM_PLAYERS-1:0][1:0] pending_nxt;

  // Pending is always judged against the committed direction, so a reversal
  // can never reach `forward`: a same-axis event only cancels the request.
  always_comb begin
    pending_nxt = pending;
    if (!paused) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!is_y_axis(committed[p])) begin
          if (dir_ev[p][KEY_Y_UP])          pending_nxt[p] = FORWARD_Y_UP;
          else if (dir_ev[p][KEY_Y_DOWN])   pending_nxt[p] = FORWARD_Y_DOWN;
          else if (dir_ev[p][KEY_X_UP] || dir_ev[p][KEY_X_DOWN])
            pending_nxt[p] = committed[p];
        end else begin
          if (dir_ev[p][KEY_X_UP])          pending_nxt[p] = FORWARD_X_UP;
          else if (dir_ev[p][KEY_X_DOWN])   pending_nxt[p] = FORWARD_X_DOWN;
          else if (dir_ev[p][KEY_Y_UP] || dir_ev[p][KEY_Y_DOWN])
            pending_nxt[p] = committed[p];
        end
      end
    end
  end

  // NOTE: these per-player arrays are a handful of flops, not a RAM, so they
  // take the async reset; a reset must drop any pending press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      committed <= '0;
      pending   <= '0;
    end else begin
      pending <= pending_nxt;
      if (wrap) committed <= pending;
    end
  end

  assign forward = committed;

endmodule

// File: tb/tb_greedy_snake_dir_ctrl.sv
// Self-checking bench for greedy_snake_dir_ctrl with small timing parameters
// (period 20 at level 0, step 2, clamp 8, debounce 3). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_greedy_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_dir;
  logic       key_pause;
  logic       key_speed_up;
  logic       key_speed_down;
  logic       en;
  logic [3:0] forward;
  logic       paused;
  logic [2:0] speed_level;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  greedy_snake_dir_ctrl #(
    .NUM_PLAYERS    (2),
    .TICK_BASE_CNT  (20),
    .SPEED_STEP_CNT (2),
    .MIN_TICK_CNT   (8),
    .SPEED_LEVELS   (8),
    .DEBOUNCE_CNT   (3),
    .AUTO_STEP_TICKS(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_dir       (key_dir),
    .key_pause     (key_pause),
    .key_speed_up  (key_speed_up),
    .key_speed_down(key_speed_down),
    .en            (en),
    .forward       (forward),
    .paused        (paused),
    .speed_level   (speed_level)
  );

  always @(posedge clk) if (en) en_cnt <= en_cnt + 1;

  typedef struct {
    logic up;
    logic down;
    int   n;
    int   exp_level;
    int   exp_period;
  } speed_vec_t;

  speed_vec_t vecs [7];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the given keys 6 cycles (event fires at the 6th edge), then release
  // and let the release debounce out before returning (11 cycles total).
  task automatic press_keys(input logic [7:0] dir, input logic p,
                            input logic u, input logic d);
    key_dir = dir; key_pause = p; key_speed_up = u; key_speed_down = d;
    step(6);
    key_dir = '0; key_pause = 1'b0; key_speed_up = 1'b0; key_speed_down = 1'b0;
    step(5);
  endtask

  task automatic wait_en(input string name, input int budget, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      step(1);
      cycles++;
      if (en) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: no en within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int snap;

    vecs[0] = '{up: 1'b1, down: 1'b0, n: 3,  exp_level: 3, exp_period: 14};
    vecs[1] = '{up: 1'b1, down: 1'b0, n: 10, exp_level: 7, exp_period: 8};
    vecs[2] = '{up: 1'b0, down: 1'b1, n: 11, exp_level: 0, exp_period: 20};
    vecs[3] = '{up: 1'b1, down: 1'b1, n: 1,  exp_level: 0, exp_period: 20};
    vecs[4] = '{up: 1'b1, down: 1'b0, n: 1,  exp_level: 1, exp_period: 18};
    vecs[5] = '{up: 1'b1, down: 1'b1, n: 2,  exp_level: 1, exp_period: 18};
    vecs[6] = '{up: 1'b0, down: 1'b1, n: 2,  exp_level: 0, exp_period: 20};

    rst = 1'b0;
    key_dir = '0; key_pause = 1'b0; key_speed_up = 1'b0; key_speed_down = 1'b0;
    step(3);
    check("rst_en", en, 0);
    check("rst_forward", forward, 0);
    check("rst_paused", paused, 0);
    check("rst_level", speed_level, 0);
    rst = 1'b1;

    // 1: idle ticks land exactly at 20, 40, 60 cycles after release.
    for (int k = 1; k <= 60; k++) begin
      step(1);
      check($sformatf("idle_en_c%0d", k), en, (k % 20 == 0) ? 1 : 0);
    end
    check("idle_forward", forward, 0);
    check("idle_paused", paused, 0);
    check("idle_level", speed_level, 0);

    // 2a: reversal attempt (x_down while X_UP) is cancelled.
    key_dir = 8'b0000_0010;
    step(10);
    key_dir = '0;
    step(10);
    check("rev_en", en, 1);
    check("rev_forward", forward, 4'b0000);

    // 2b: y_up then y_down in one period; last one wins, only at the tick.
    key_dir = 8'b0000_0100;
    step(3);
    key_dir = 8'b0000_1100;
    step(5);
    key_dir = '0;
    step(11);
    check("lastwins_pre_en", en, 0);
    check("lastwins_pre_forward", forward, 4'b0000);
    step(1);
    check("lastwins_en", en, 1);
    check("lastwins_forward", forward, 4'b0011);

    // 3: player1 y_up and y_down together -> y_up priority; player0 kept.
    press_keys(8'b1100_0000, 1'b0, 1'b0, 1'b0);
    step(8);
    check("p1_pre_forward", forward, 4'b0011);
    step(1);
    check("p1_en", en, 1);
    check("p1_forward", forward, 4'b1011);

    // 4: speed table, each row checked for level and measured period.
    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++)
        press_keys(8'h00, 1'b0, vecs[i].up, vecs[i].down);
      check($sformatf("speed_level_row%0d", i), speed_level, vecs[i].exp_level);
      wait_en($sformatf("speed_sync_row%0d", i), 60, c);
      wait_en($sformatf("speed_meas_row%0d", i), 60, c);
      check($sformatf("speed_period_row%0d", i), c, vecs[i].exp_period);
    end

    // 5: pause freezing the count at 10, direction keys ignored, glitch
    //    rejected, resume from the frozen count.
    wait_en("pause_sync", 60, c);
    step(3);
    key_pause = 1'b1;
    step(6);
    key_pause = 1'b0;
    check("pause_not_yet", paused, 0);
    step(1);
    check("pause_set", paused, 1);
    snap = en_cnt;
    press_keys(8'b0000_0001, 1'b0, 1'b0, 1'b0);
    key_pause = 1'b1;
    step(2);
    key_pause = 1'b0;
    step(8);
    check("glitch_paused", paused, 1);
    step(22);
    key_pause = 1'b1;
    step(6);
    key_pause = 1'b0;
    check("unpause_not_yet", paused, 1);
    step(1);
    check("unpause", paused, 0);
    check("pause_no_en", en_cnt - snap, 0);
    step(9);
    check("resume_pre_en", en, 0);
    step(1);
    check("resume_en", en, 1);
    check("resume_forward", forward, 4'b1011);

    // 6: reset mid-period drops a pending Y_UP and the speed level.
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    press_keys(8'b0000_0100, 1'b0, 1'b1, 1'b0);
    check("pre_reset_level", speed_level, 1);
    check("pre_reset_forward", forward, 0);
    rst = 1'b0;
    #1;
    check("midrst_en", en, 0);
    check("midrst_forward", forward, 0);
    check("midrst_paused", paused, 0);
    check("midrst_level", speed_level, 0);
    step(2);
    rst = 1'b1;
    step(19);
    check("postrst_pre_en", en, 0);
    step(1);
    check("postrst_en", en, 1);
    check("postrst_forward", forward, 0);
    check("postrst_level", speed_level, 0);

`ifdef GREEDY_SNAKE_AUTO_SPEED_EN
    wait_en("auto_en2", 60, c);
    wait_en("auto_en3", 60, c);
    check("auto_level_en3", speed_level, 0);
    wait_en("auto_en4", 60, c);
    check("auto_level_en4", speed_level, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/greedy_snake_dir_ctrl.md
Name: greedy_snake_dir_ctrl

Overview:
Multi-player direction and game-tick controller for the GreedySnake game. Takes raw push-buttons, then synchronises, debounces and edge-detects them. Holds one direction per player with reversal rejection and generates the movement tick (en) at a speed-level-dependent period, with pause support. Sits between the board keys and the snake body/BSRAM update logic.

Parameters:
NUM_PLAYERS, 2, number of independent snakes (1..4)
TICK_BASE_CNT, 27_000_000, tick period in clk cycles at speed level 0
SPEED_STEP_CNT, 2_700_000, cycles removed from the period per speed level
MIN_TICK_CNT, 5_400_000, lower clamp on the tick period
SPEED_LEVELS, 8, number of speed levels (level range 0..SPEED_LEVELS-1)
DEBOUNCE_CNT, 270_000, consecutive stable cycles needed to accept a key level
AUTO_STEP_TICKS, 32, ticks per automatic speed step (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
key_dir  in  4*NUM_PLAYERS  raw active-high keys; player p bits [4p+0]=x_up, [4p+1]=x_down, [4p+2]=y_up, [4p+3]=y_down
key_pause  in  1  raw active-high pause toggle key
key_speed_up  in  1  raw active-high speed increment key
key_speed_down  in  1  raw active-high speed decrement key
en  out  1  one-cycle movement tick
forward  out  2*NUM_PLAYERS  committed direction; player p = bits [2p+1:2p]; 00 X_UP, 01 X_DOWN, 10 Y_UP, 11 Y_DOWN
paused  out  1  high while the game is paused
speed_level  out  clog2(SPEED_LEVELS)  current speed level

Behaviour:
- Reset (async, rst=0): en=0, forward=all 00, paused=0, speed_level=0. Tick counter, pending directions and debouncer state all clear. Reset mid-operation discards pending presses.
- Key path (every key): 2-FF synchroniser, then a debouncer. The debounced level changes only after DEBOUNCE_CNT consecutive equal samples that differ from the current level. A press event is a 1-cycle pulse on the debounced rising edge. Total press latency is 2+DEBOUNCE_CNT+1 cycles.
- Each player holds two registers: committed (drives forward) and pending.
- Pending is evaluated against the committed direction, never against pending.
  - If committed is on the X axis: a y_up event sets pending to Y_UP, else a y_down event sets Y_DOWN; X-axis events set pending to committed (cancel).
  - If committed is on the Y axis: symmetric, with x_up taking priority over x_down.
  - Reversal is therefore never committed. The last accepted event within a tick period wins.
- Tick counter: period P = max(MIN_TICK_CNT, TICK_BASE_CNT - speed_level*SPEED_STEP_CNT).
  - Counter counts 0..P-1. When counter >= P-1 it wraps to 0; `>=` handles a mid-count period shrink.
  - The registered en pulses 1 cycle on the wrap, and every committed <= pending on that same clk edge.
  - The first en arrives P cycles after reset release.
- Speed events: speed_up increments and speed_down decrements speed_level, each saturating at its bound. The new level applies to the in-flight count immediately. Simultaneous up and down events leave the level unchanged.
- Pause event toggles paused. While paused: counter frozen, en=0, direction events ignored, pending held, speed events still accepted. Unpausing resumes the count from the frozen value.
- Pause and tick wrap in the same cycle: the tick completes (en=1) and paused sets afterwards.
- All outputs are registered.

Optional Feature:
Macro GREEDY_SNAKE_AUTO_SPEED_EN.
- Defined: a tick counter increments speed_level (saturating) every AUTO_STEP_TICKS en pulses. Manual speed keys remain active. The auto count resets on reset only.
- Undefined: speed_level changes only via keys, and no auto counter logic is built.

Decomposition:
- Package greedy_snake_pkg holds:
  - direction encodings FORWARD_X_UP/X_DOWN/Y_UP/Y_DOWN;
  - key bit offsets KEY_X_UP=0, KEY_X_DOWN=1, KEY_Y_UP=2, KEY_Y_DOWN=3.
- One sub-module, greedy_snake_key_debounce: synchroniser, debouncer and rising-edge pulse, parameterised by DEBOUNCE_CNT. It is instantiated 4*NUM_PLAYERS+3 times via generate.

Test Plan:
All scenarios use bench params TICK_BASE_CNT=20, SPEED_STEP_CNT=2, MIN_TICK_CNT=8, SPEED_LEVELS=8, DEBOUNCE_CNT=3.
1. Release reset, no keys -> forward=0000, paused=0, speed_level=0; en pulses exactly at cycles 20, 40, 60 after release.
2. Player0 committed X_UP: hold x_down 10 cycles -> forward[1:0] stays 00 after the next en. Then hold y_up, later y_down, both in one period -> forward[1:0]=11 at the next en only, not before.
3. Player1 asserts y_up and y_down on the same cycle while X_UP -> forward[3:2]=10 at the next en. Player0 is unaffected.
4. Three speed_up presses -> speed_level=3, period 14. Ten more presses -> level saturates at 7, period clamped to 8. Eleven speed_down presses -> level 0.
5. Pause at counter 10 -> no en and direction keys ignored. Unpause 50 cycles later -> en 10 cycles later. A 2-cycle key glitch produces no event.
6. Assert rst mid-period with a pending Y_UP -> all outputs return to reset values and the pending press is lost. With GREEDY_SNAKE_AUTO_SPEED_EN and AUTO_STEP_TICKS=4, speed_level reaches 1 at the 4th en.
